// File: rtl/spi_lcd_pkg.sv
// Shared types and constants for the LCD SPI receive path.
// Covers the command opcodes, the decoder and link states, and the tagged byte format.
package spi_lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_PARAM,
    DEC_PIXEL
  } dec_state_t;

  typedef enum logic {
    LINK_IDLE,
    LINK_ACTIVE
  } link_state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } lcd_byte_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync.sv
// Single-bit flip-flop synchronizer for signals entering the clk domain.
// The chain clears on reset, so every pin reads as 0 until fresh samples arrive.
module sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample
  // the values from before the edge regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with full and empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers and count
  // decide what is valid, and resetting a RAM would prevent it mapping to memory cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_lcd_sink.sv
// SPI mode-0 target for the LCD link: oversamples the pins, rebuilds D/C-tagged bytes,
// queues them in a FWFT FIFO and tracks the last command and pixel count since RAMWR.
module spi_lcd_sink
  import spi_lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  input  logic        lcd_dc,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        overflow,
  output logic        frame_err,
  output logic [7:0]  cmd_last,
  output logic [15:0] pixel_count
);

  logic        sclk_s, mosi_s, cs_s, dc_s;
  logic        sclk_d, cs_d;
  logic        sclk_rise, cs_rise, cs_fall;
  logic        shift_en;
  logic [6:0]  shift;
  logic [2:0]  bit_cnt;
  logic        byte_done;
  lcd_byte_t   byte_q;
  lcd_byte_t   head;
  logic        fifo_full, fifo_empty;
  logic        pop_fire;
  link_state_t state, state_nx;
  dec_state_t  dstate;

  sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .reset_n(reset_n), .d(spi_clk),  .q(sclk_s));
  sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(spi_mosi), .q(mosi_s));
  sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(clk), .reset_n(reset_n), .d(spi_cs_n), .q(cs_s));
  sync #(.STAGES(SYNC_STAGES)) u_sync_dc   (.clk(clk), .reset_n(reset_n), .d(lcd_dc),   .q(dc_s));

  assign sclk_rise = sclk_s && !sclk_d;
  assign cs_rise   = cs_s && !cs_d;
  assign cs_fall   = !cs_s && cs_d;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= LINK_IDLE;
    else          state <= state_nx;
  end

  // NOTE: every output of this block is given a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    if (cs_rise)      state_nx = LINK_IDLE;
    else if (cs_fall) state_nx = LINK_ACTIVE;
    if (state == LINK_ACTIVE && !cs_s && sclk_rise) shift_en = 1'b1;
  end

  // Deserializer: the completed byte is registered here and pushed one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      if (cs_rise) begin
        frame_err <= (bit_cnt != 3'd0);
        bit_cnt   <= '0;
      end else if (cs_fall) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift <= {shift[5:0], mosi_s};
        if (bit_cnt == 3'd7) begin
          byte_done   <= 1'b1;
          byte_q.dc   <= dc_s;
          byte_q.data <= {shift, mosi_s};
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH($bits(lcd_byte_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (byte_done),
    .push_data(byte_q),
    .pop      (rx_ready),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign pop_fire = rx_valid && rx_ready;
  assign rx_data  = rx_valid ? head.data : 8'h00;
  assign rx_dc    = rx_valid && head.dc;

  always_ff @(posedge clk) begin
    if (!reset_n)                              overflow <= 1'b0;
    else if (byte_done && fifo_full && !pop_fire) overflow <= 1'b1;
  end

  // The decoder follows every completed byte, even one the FIFO had to drop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dstate      <= DEC_NONE;
      cmd_last    <= '0;
      pixel_count <= '0;
    end else if (byte_done) begin
      if (!byte_q.dc) begin
        cmd_last <= byte_q.data;
        if (byte_q.data == CMD_RAMWR) begin
          pixel_count <= '0;
          dstate      <= DEC_PIXEL;
        end else begin
          dstate <= DEC_PARAM;
        end
      end else if (dstate == DEC_PIXEL) begin
        pixel_count <= sat_inc16(pixel_count);
      end
    end
  end

endmodule
